// File: rtl/bidir_xcvr_pkg.sv
// Shared types and helpers for the bidirectional bus transceiver.
// The optional parity feature (macro XCVR_PARITY_EN) uses even_par.
package bidir_xcvr_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} xcvr_st_e;

    // Widest vector even_par accepts; callers zero-extend, which keeps parity intact.
    localparam int PAR_MAX_W = 64;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/bidir_pad_drv.sv
// Tri-state pad driver: drives pad with d while oe is high, releases it otherwise.
module bidir_pad_drv #(
    parameter int W = 6
) (
    input  logic         oe,
    input  logic [W-1:0] d,
    inout  wire  [W-1:0] pad
);

    assign pad = oe ? d : {W{1'bz}};

endmodule

// File: rtl/bidir_bus_xcvr.sv
// Sequenced transceiver for a shared bidirectional bus with turnaround insertion.
// Define XCVR_PARITY_EN to add the bus_par lane and the rd_perr read-parity flag.
module bidir_bus_xcvr
    import bidir_xcvr_pkg::*;
#(
    parameter int W          = 6,
    parameter int TURN_CYC   = 1,
    parameter int SAMPLE_DLY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    input  logic         rd_req,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         bus_oe,
`ifdef XCVR_PARITY_EN
    inout  wire          bus_par,
    output logic         rd_perr,
`endif
    inout  wire  [W-1:0] bus
);

    localparam int MAXC = (TURN_CYC > SAMPLE_DLY) ? TURN_CYC : SAMPLE_DLY;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SMP_LOAD  = CW'(SAMPLE_DLY - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam xcvr_st_e      POST_ST   = (TURN_CYC > 0) ? TURN : IDLE;

    xcvr_st_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  drv_q, drv_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          wr_ready_q, wr_ready_d;
    logic          bus_oe_q, bus_oe_d;
    logic          rd_valid_q, rd_valid_d;
    logic          capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drv_q      <= '0;
            rd_data_q  <= '0;
            wr_ready_q <= 1'b0;
            bus_oe_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drv_q      <= drv_d;
            rd_data_q  <= rd_data_d;
            wr_ready_q <= wr_ready_d;
            bus_oe_q   <= bus_oe_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state: a write wins over a simultaneous read request in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    state_d = DRIVE;
                    drv_d   = wr_data;
                end else if (rd_req) begin
                    state_d = SAMPLE;
                    cnt_d   = SMP_LOAD;
                end
            end
            DRIVE: begin
                state_d = POST_ST;
                cnt_d   = TURN_LOAD;
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = POST_ST;
                    cnt_d   = TURN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered so every port comes straight from a flop.
    always_comb begin
        wr_ready_d = (state_d == IDLE);
        bus_oe_d   = (state_d == DRIVE);
        rd_valid_d = capture;
        rd_data_d  = capture ? bus : rd_data_q;
    end

    assign wr_ready = wr_ready_q;
    assign bus_oe   = bus_oe_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q != IDLE);

    bidir_pad_drv #(.W(W)) u_bus_pad (
        .oe  (bus_oe_q),
        .d   (drv_q),
        .pad (bus)
    );

`ifdef XCVR_PARITY_EN
    logic par_q, par_d;
    logic rd_perr_q, rd_perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= 1'b0;
            rd_perr_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            rd_perr_q <= rd_perr_d;
        end
    end

    // Parity rides along with the latched write data and with the captured read data.
    always_comb begin
        par_d     = (state_q == IDLE && state_d == DRIVE) ? even_par(PAR_MAX_W'(wr_data)) : par_q;
        rd_perr_d = capture ? (even_par(PAR_MAX_W'(bus)) != bus_par) : rd_perr_q;
    end

    assign rd_perr = rd_perr_q;

    bidir_pad_drv #(.W(1)) u_par_pad (
        .oe  (bus_oe_q),
        .d   (par_q),
        .pad (bus_par)
    );
`endif

endmodule

// File: tb/tb_bidir_bus_xcvr.sv
// Directed bench for bidir_bus_xcvr: default build plus a TURN_CYC=0 instance.
// Parity checks are compiled in when XCVR_PARITY_EN is defined.
module tb_bidir_bus_xcvr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_valid, wr_ready, rd_req, rd_valid, busy, bus_oe;
    logic [5:0] wr_data, rd_data;
    logic       ext_oe;
    logic [5:0] ext_val;
    wire  [5:0] bus;

    logic       wr_valid0, wr_ready0, rd_req0, rd_valid0, busy0, bus_oe0;
    logic [5:0] wr_data0, rd_data0;
    wire  [5:0] bus0;

    int total = 0;
    int bad   = 0;
    int clash = 0;

    assign bus = ext_oe ? ext_val : 6'bz;

`ifdef XCVR_PARITY_EN
    logic ext_par;
    logic rd_perr, rd_perr0;
    wire  bus_par, bus_par0;
    assign bus_par = ext_oe ? ext_par : 1'bz;
`endif

    bidir_bus_xcvr #(.W(6), .TURN_CYC(1), .SAMPLE_DLY(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .bus_oe   (bus_oe),
`ifdef XCVR_PARITY_EN
        .bus_par  (bus_par),
        .rd_perr  (rd_perr),
`endif
        .bus      (bus)
    );

    bidir_bus_xcvr #(.W(6), .TURN_CYC(0), .SAMPLE_DLY(1)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid0),
        .wr_ready (wr_ready0),
        .wr_data  (wr_data0),
        .rd_req   (rd_req0),
        .rd_valid (rd_valid0),
        .rd_data  (rd_data0),
        .busy     (busy0),
        .bus_oe   (bus_oe0),
`ifdef XCVR_PARITY_EN
        .bus_par  (bus_par0),
        .rd_perr  (rd_perr0),
`endif
        .bus      (bus0)
    );

    // Both ends driving the shared bus in the same cycle is contention.
    always @(negedge clk) begin
        if (rst_n && bus_oe && ext_oe) clash++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 6'h00;
        rd_req    = 1'b0;
        ext_oe    = 1'b0;
        ext_val   = 6'h00;
        wr_valid0 = 1'b0;
        wr_data0  = 6'h00;
        rd_req0   = 1'b0;
`ifdef XCVR_PARITY_EN
        ext_par   = 1'b0;
`endif

        // Reset state
        step();
        chk("rst_busy", busy, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        chk("wr_ready_before_edge", wr_ready, 0);
        step();
        chk("wr_ready_after_edge", wr_ready, 1);
        chk("idle_busy", busy, 0);

        // Single write of 6'h2A
        wr_data  = 6'h2A;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("wr_drive_oe", bus_oe, 1);
        chk("wr_drive_bus", bus, 6'h2A);
        chk("wr_drive_busy", busy, 1);
        chk("wr_drive_ready", wr_ready, 0);
`ifdef XCVR_PARITY_EN
        chk("wr_drive_par", bus_par, 1);
`endif
        step();
        chk("wr_turn_oe", bus_oe, 0);
        chk("wr_turn_ready", wr_ready, 0);
        step();
        chk("wr_idle_ready", wr_ready, 1);
        chk("wr_idle_busy", busy, 0);

        // Read of an externally driven 6'h15
        ext_val = 6'h15;
        ext_oe  = 1'b1;
        rd_req  = 1'b1;
        step();
        chk("rd_sample_valid", rd_valid, 0);
        chk("rd_sample_oe", bus_oe, 0);
        chk("rd_sample_busy", busy, 1);
        step();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, 6'h15);
        rd_req = 1'b0;
        ext_oe = 1'b0;
        step();
        chk("rd_valid_pulse", rd_valid, 0);
        chk("rd_idle_busy", busy, 0);

        // Simultaneous write and read: write goes first
        wr_data  = 6'h33;
        wr_valid = 1'b1;
        rd_req   = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("col_drive_oe", bus_oe, 1);
        chk("col_drive_bus", bus, 6'h33);
        step();
        chk("col_turn_oe", bus_oe, 0);
        chk("col_turn_valid", rd_valid, 0);
        ext_val = 6'h0C;
        ext_oe  = 1'b1;
        step();
        chk("col_idle_busy", busy, 0);
        step();
        chk("col_sample_busy", busy, 1);
        chk("col_sample_valid", rd_valid, 0);
        step();
        chk("col_rd_valid", rd_valid, 1);
        chk("col_rd_data", rd_data, 6'h0C);
        rd_req = 1'b0;
        ext_oe = 1'b0;
        step();

        // TURN_CYC=0 instance: back-to-back writes accepted every 2 cycles
        wr_data0  = 6'h01;
        wr_valid0 = 1'b1;
        step();
        chk("t0_w1_oe", bus_oe0, 1);
        chk("t0_w1_bus", bus0, 6'h01);
        chk("t0_w1_ready", wr_ready0, 0);
        wr_data0 = 6'h02;
        step();
        chk("t0_gap_oe", bus_oe0, 0);
        chk("t0_gap_ready", wr_ready0, 1);
        chk("t0_gap_busy", busy0, 0);
        step();
        wr_valid0 = 1'b0;
        chk("t0_w2_oe", bus_oe0, 1);
        chk("t0_w2_bus", bus0, 6'h02);
        step();
        chk("t0_w2_release", bus_oe0, 0);

`ifdef XCVR_PARITY_EN
        // Parity on reads: ^6'h07 = 1
        ext_val = 6'h07;
        ext_par = 1'b0;
        ext_oe  = 1'b1;
        rd_req  = 1'b1;
        step();
        step();
        chk("par_bad_valid", rd_valid, 1);
        chk("par_bad_perr", rd_perr, 1);
        rd_req = 1'b0;
        step();
        step();
        ext_par = 1'b1;
        rd_req  = 1'b1;
        step();
        step();
        chk("par_ok_valid", rd_valid, 1);
        chk("par_ok_perr", rd_perr, 0);
        rd_req = 1'b0;
        ext_oe = 1'b0;
        step();
        step();
`endif

        // Asynchronous reset while driving
        wr_data  = 6'h3F;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("mid_drive_oe", bus_oe, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", bus_oe, 0);
        chk("arst_bus_released", (bus === 6'h3F), 0);
        chk("arst_busy", busy, 0);
        chk("arst_wr_ready", wr_ready, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_data", rd_data, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_recover_ready", wr_ready, 1);

        chk("no_contention", clash, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
